led_frame_scheduler: RTL and testbench
======================================

LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 SHALL have parameter LED_CNT, default 3, number of RGB LEDs; NBYTES = LED_CNT*3, FRAME_W = NBYTES*8.
REQ-002 SHALL have parameter CLK_SPEED, default 25_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter GAP_US, default 60, minimum idle time between serializer transmissions, in microseconds; GAP_CYCLES = CLK_SPEED/1_000_000*GAP_US.
REQ-004 Ports, clock and reset first:
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_start  in  1  one-cycle pulse, bus transaction start.
REQ-008 wr_stop  in  1  one-cycle pulse, bus transaction stop.
REQ-009 wr_index  in  8  starting byte index, sampled on wr_start.
REQ-010 wr_data  in  8  write byte, qualified by wr_valid.
REQ-011 wr_valid  in  1  one-cycle pulse, wr_data valid.
REQ-012 tx_busy  in  1  serializer transmitting.
REQ-013 frame_o  out  FRAME_W  active frame to serializer.
REQ-014 tx_req  out  1  transmit request to serializer.
REQ-015 commit_o  out  1  one-cycle pulse, shadow copied to active.
REQ-016 pending_o  out  1  completed write awaiting commit.
REQ-017 overflow_o  out  1  sticky, a byte was dropped as out of range.

Function
REQ-018 SHALL hold a shadow frame (written by bus) and an active frame (drives frame_o); frame_o SHALL change only on commit.
REQ-019 Write FSM W_IDLE/W_ACTIVE: wr_start in any state -> W_ACTIVE, idx <= wr_index, overflow_o <= 0, written <= 0.
REQ-020 In W_ACTIVE, wr_valid with idx < NBYTES SHALL store wr_data[7-i] into shadow bit 8*idx+i (i=0..7), idx <= idx+1, written <= 1.
REQ-021 wr_valid with idx >= NBYTES SHALL drop the byte, set overflow_o, leave idx unchanged (no wrap).
REQ-022 wr_stop in W_ACTIVE -> W_IDLE; pending_o <= 1 if written, else unchanged.
REQ-023 wr_valid/wr_stop in W_IDLE SHALL be ignored; wr_start and wr_valid in same cycle: start wins, byte ignored.
REQ-024 Send FSM S_IDLE/S_REQ/S_BUSY/S_GAP.
REQ-025 S_IDLE: pending_o=1 and write FSM in W_IDLE -> copy shadow to active, commit_o=1 for that cycle, pending_o <= 0, -> S_REQ.
REQ-026 Commit SHALL NOT occur while write FSM is W_ACTIVE (atomic frames); a pending frame waits until the next wr_stop.
REQ-027 wr_stop and commit eligibility in the same cycle: pending set, commit the following cycle.
REQ-028 S_REQ: tx_req=1; tx_busy=1 -> S_BUSY, tx_req drops on the same edge.
REQ-029 S_BUSY: tx_busy=0 -> S_GAP, gap counter loaded with GAP_CYCLES-1.
REQ-030 S_GAP: count down to 0 then -> S_IDLE; earliest next commit GAP_CYCLES+1 cycles after tx_busy falls.
REQ-031 Writes SHALL continue to shadow in all send states; a new complete write during S_REQ..S_GAP leaves pending_o=1.

Reset
REQ-032 reset low SHALL immediately clear: both FSMs to idle states, shadow and active frames 0, frame_o 0, tx_req 0, commit_o 0, pending_o 0, overflow_o 0, idx 0, gap counter 0.
REQ-033 Reset mid-transmission SHALL drop tx_req with no further handshake; first action after release requires a new write.

Structure
REQ-034 Shared package led_pkg SHALL hold write/send state encodings and NBYTES/FRAME_W/GAP_CYCLES derivation functions.
REQ-035 One sub-module led_gap_timer (loadable down-counter, done flag) SHALL implement S_GAP timing.

Verification (LED_CNT=3, GAP_US giving GAP_CYCLES=10)
REQ-036 start idx=0, bytes 0x80,0x01,..9 bytes, stop -> one commit_o, frame_o bit0=1, bit15=1, tx_req until tx_busy.
REQ-037 start idx=7, 4 bytes, stop -> bytes 7,8 stored, overflow_o=1, pending_o=1, commit after stop.
REQ-038 second write completes during S_BUSY -> pending_o held; commit exactly 11 cycles after tx_busy falls.
REQ-039 new start while pending and S_IDLE -> no commit until its stop; frame_o then contains both writes.
REQ-040 reset low during S_BUSY with pending_o=1 -> all outputs 0 asynchronously; tx_busy toggling afterwards causes no commit.
REQ-041 start then stop with no bytes -> pending_o stays 0, no tx_req.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings and parameter derivations for the LED frame scheduler.
package led_pkg;

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_GAP  = 2'd3
  } snd_state_e;

  function automatic int calc_nbytes(input int led_cnt);
    return led_cnt * 3;
  endfunction

  function automatic int calc_frame_w(input int led_cnt);
    return led_cnt * 24;
  endfunction

  function automatic int calc_gap_cycles(input int clk_speed, input int gap_us);
    return clk_speed / 1_000_000 * gap_us;
  endfunction

  function automatic int calc_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bus bytes arrive MSB first, the serializer shifts frame bit 0 first.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/led_gap_timer.sv
// Loadable down-counter that times the idle gap between transmissions.
module led_gap_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered LED frame: bus writes fill a shadow frame, which is committed
// atomically to the active frame and handed to the serializer with a min idle gap.
//   state    | meaning
//   W_IDLE   | no bus transaction open
//   W_ACTIVE | bus transaction open, bytes land in shadow
//   S_IDLE   | waiting for a pending frame and a closed transaction
//   S_REQ    | tx_req raised, waiting for serializer to go busy
//   S_BUSY   | serializer transmitting
//   S_GAP    | enforcing idle gap before the next commit
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int LED_CNT   = 3,
  parameter int CLK_SPEED = 25_000_000,
  parameter int GAP_US    = 60
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_start,
  input  logic                              wr_stop,
  input  logic [7:0]                        wr_index,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_valid,
  input  logic                              tx_busy,
  output logic [calc_frame_w(LED_CNT)-1:0]  frame_o,
  output logic                              tx_req,
  output logic                              commit_o,
  output logic                              pending_o,
  output logic                              overflow_o
);

  localparam int NBYTES     = calc_nbytes(LED_CNT);
  localparam int FRAME_W    = calc_frame_w(LED_CNT);
  localparam int GAP_CYCLES = calc_gap_cycles(CLK_SPEED, GAP_US);
  localparam int CNT_W      = calc_cnt_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  wr_state_e          w_state_q, w_state_d;
  snd_state_e         s_state_q, s_state_d;
  logic [7:0]         idx_q, idx_d;
  logic               written_q, written_d;
  logic               pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] active_q, active_d;
  logic               store;
  logic               commit;
  logic               gap_load;
  logic               gap_done;

  // Write FSM: wr_start always restarts the transaction, even mid-transfer.
  always_comb begin
    w_state_d  = w_state_q;
    idx_d      = idx_q;
    written_d  = written_q;
    overflow_d = overflow_q;
    pending_d  = pending_q;
    store      = 1'b0;
    if (commit) pending_d = 1'b0;
    if (wr_start) begin
      w_state_d  = W_ACTIVE;
      idx_d      = wr_index;
      overflow_d = 1'b0;
      written_d  = 1'b0;
    end else if (w_state_q == W_ACTIVE) begin
      if (wr_valid) begin
        if (int'(idx_q) < NBYTES) begin
          store     = 1'b1;
          idx_d     = idx_q + 8'd1;
          written_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (wr_stop) begin
        w_state_d = W_IDLE;
        if (written_d) pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int b = 0; b < NBYTES; b++) begin
      if (store && (int'(idx_q) == b)) shadow_d[8*b +: 8] = bit_rev8(wr_data);
    end
  end

  // Send FSM: commit only when no transaction is open so frames stay atomic.
  always_comb begin
    s_state_d = s_state_q;
    active_d  = active_q;
    commit    = 1'b0;
    gap_load  = 1'b0;
    case (s_state_q)
      S_IDLE: begin
        if (pending_q && (w_state_q == W_IDLE)) begin
          commit    = 1'b1;
          active_d  = shadow_q;
          s_state_d = S_REQ;
        end
      end
      S_REQ:  if (tx_busy) s_state_d = S_BUSY;
      S_BUSY: begin
        if (!tx_busy) begin
          gap_load  = 1'b1;
          s_state_d = S_GAP;
        end
      end
      S_GAP:  if (gap_done) s_state_d = S_IDLE;
      default: s_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      s_state_q  <= S_IDLE;
      idx_q      <= '0;
      written_q  <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      s_state_q  <= s_state_d;
      idx_q      <= idx_d;
      written_q  <= written_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  led_gap_timer #(.CNT_W(CNT_W)) u_gap_timer (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .done_o     (gap_done)
  );

  assign frame_o    = active_q;
  assign tx_req     = (s_state_q == S_REQ);
  assign commit_o   = commit;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with 3 LEDs and a 10-cycle gap.
module tb_led_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_start = 1'b0;
  logic        wr_stop = 1'b0;
  logic [7:0]  wr_index = 8'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [71:0] frame_o;
  logic        tx_req;
  logic        commit_o;
  logic        pending_o;
  logic        overflow_o;

  int vecs = 0;
  int errs = 0;
  int ncommit = 0;
  int base;
  int edges;

  led_frame_scheduler #(
    .LED_CNT   (3),
    .CLK_SPEED (1_000_000),
    .GAP_US    (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_start   (wr_start),
    .wr_stop    (wr_stop),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .tx_busy    (tx_busy),
    .frame_o    (frame_o),
    .tx_req     (tx_req),
    .commit_o   (commit_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (commit_o) ncommit <= ncommit + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] idx);
    wr_start = 1'b1; wr_index = idx;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b);
    wr_valid = 1'b1; wr_data = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_stop();
    wr_stop = 1'b1;
    tick();
    wr_stop = 1'b0;
  endtask

  task automatic finish_tx();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    repeat (13) tick();
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_frame", frame_o, 72'h0);
    chk("rst_txreq", tx_req, 1'b0);
    chk("rst_commit", commit_o, 1'b0);
    chk("rst_pending", pending_o, 1'b0);
    chk("rst_overflow", overflow_o, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // full frame write from index 0
    base = ncommit;
    do_start(8'd0);
    do_byte(8'h80);
    do_byte(8'h01);
    repeat (7) do_byte(8'h00);
    do_stop();
    chk("t1_pending", pending_o, 1'b1);
    chk("t1_commit", commit_o, 1'b1);
    chk("t1_frame_before", frame_o, 72'h0);
    tick();
    chk("t1_frame", frame_o, 72'h8001);
    chk("t1_pending_clr", pending_o, 1'b0);
    chk("t1_txreq", tx_req, 1'b1);
    repeat (3) tick();
    chk("t1_txreq_hold", tx_req, 1'b1);
    chk("t1_ncommit", ncommit - base, 1);
    tx_busy = 1'b1;
    tick();
    chk("t1_txreq_drop", tx_req, 1'b0);

    // second write completes while busy, commit waits for the gap
    do_start(8'd3);
    do_byte(8'hFF);
    do_stop();
    chk("t3_pending_held", pending_o, 1'b1);
    chk("t3_no_commit", commit_o, 1'b0);
    tx_busy = 1'b0;
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      edges++;
      if (commit_o) break;
    end
    chk("t3_commit_latency", edges, 11);
    tick();
    chk("t3_frame", frame_o, 72'hFF008001);
    chk("t3_txreq", tx_req, 1'b1);
    finish_tx();

    // write running past the last byte
    do_start(8'd7);
    do_byte(8'hAA);
    do_byte(8'h0F);
    do_byte(8'h11);
    chk("t2_overflow_mid", overflow_o, 1'b1);
    do_byte(8'h22);
    do_stop();
    chk("t2_overflow", overflow_o, 1'b1);
    chk("t2_pending", pending_o, 1'b1);
    chk("t2_commit", commit_o, 1'b1);
    tick();
    chk("t2_frame", frame_o, 72'hF055000000FF008001);

    // pending frame held back by an open transaction
    tx_busy = 1'b1;
    tick();
    do_start(8'd2);
    do_byte(8'h03);
    do_stop();
    do_start(8'd6);
    tx_busy = 1'b0;
    repeat (13) tick();
    base = ncommit;
    do_start(8'd4);
    chk("t4_overflow_clr", overflow_o, 1'b0);
    repeat (4) tick();
    chk("t4_no_commit", commit_o, 1'b0);
    chk("t4_pending", pending_o, 1'b1);
    chk("t4_frame_hold", frame_o, 72'hF055000000FF008001);
    do_byte(8'hC0);
    do_stop();
    chk("t4_commit", commit_o, 1'b1);
    tick();
    chk("t4_frame", frame_o, 72'hF0550000_03FFC08001);
    chk("t4_ncommit", ncommit - base, 1);

    // asynchronous reset while busy with a pending frame
    tx_busy = 1'b1;
    tick();
    do_start(8'd0);
    do_byte(8'h12);
    do_stop();
    chk("t5_pending_pre", pending_o, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t5_frame", frame_o, 72'h0);
    chk("t5_txreq", tx_req, 1'b0);
    chk("t5_pending", pending_o, 1'b0);
    chk("t5_commit", commit_o, 1'b0);
    chk("t5_overflow", overflow_o, 1'b0);
    tick();
    reset = 1'b1;
    base = ncommit;
    tx_busy = 1'b0; tick();
    tx_busy = 1'b1; tick();
    tx_busy = 1'b0;
    repeat (15) tick();
    chk("t5_ncommit", ncommit - base, 0);
    chk("t5_txreq_after", tx_req, 1'b0);

    // empty transaction, and a start that swallows a same-cycle byte
    base = ncommit;
    do_start(8'd0);
    do_stop();
    wr_start = 1'b1; wr_index = 8'd0; wr_valid = 1'b1; wr_data = 8'hFF;
    tick();
    wr_start = 1'b0; wr_valid = 1'b0;
    do_stop();
    repeat (3) tick();
    chk("t6_pending", pending_o, 1'b0);
    chk("t6_txreq", tx_req, 1'b0);
    chk("t6_ncommit", ncommit - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
